// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter: pipeline writeback vs. buffered auxiliary writes
//
// The pipeline writeback always owns the single write port when it is valid.
// Auxiliary writes are queued in a small FIFO and drained into cycles where
// the pipeline does not write. A blocked, non-empty queue eventually raises
// stall_req so the pipeline gives the port up.
//
// Parameters:
//   DEPTH          auxiliary FIFO entries (power of two, 2..8)
//   STARVE_MAX     consecutive blocked cycles before stall_req (1..15)
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   pipe_wb_en     pipeline writeback valid
//   pipe_wb_dest   pipeline destination register
//   pipe_wb_value  pipeline write data
//   aux_valid      auxiliary write request
//   aux_ready      auxiliary request accepted at next posedge when aux_valid
//   aux_dest       auxiliary destination register
//   aux_value      auxiliary write data
//   writeBackEn    register file write enable
//   Dest_wb        register file write address
//   Result_wb      register file write data
//   pend_mask      bit r set while a queued entry targets register r (0..14)
//   stall_req      asks the pipeline to hold pipe_wb_en low
//   protocol_err   sticky: pipeline wrote while stall_req was high

module regfile_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wb_en,
    input  logic [3:0]  pipe_wb_dest,
    input  logic [31:0] pipe_wb_value,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [3:0]  aux_dest,
    input  logic [31:0] aux_value,
    output logic        writeBackEn,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_wb,
    output logic [14:0] pend_mask,
    output logic        stall_req,
    output logic        protocol_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]       dest_q  [DEPTH];
    logic [31:0]      value_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       starve_cnt;
    logic             perr_q;
    logic             push;
    logic             pop;
    logic             queue_empty;

    assign queue_empty  = (count == '0);
    // Ready looks only at current occupancy so a full queue stays closed
    // even in the cycle it is being drained.
    assign aux_ready    = (count != FULL_COUNT);
    assign push         = aux_valid && aux_ready;
    assign pop          = !pipe_wb_en && !queue_empty;
    assign stall_req    = (starve_cnt == STARVE_LIM);
    assign protocol_err = perr_q;

    // Entry payload needs no reset: valid_q qualifies every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr]  <= aux_dest;
            value_q[wr_ptr] <= aux_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_q    <= '0;
            starve_cnt <= '0;
            perr_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                valid_q[wr_ptr] <= 1'b1;
            end
            // A push and a pop never share a slot: pop needs count > 0 and
            // push needs count < DEPTH, so the pointers differ.
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Count cycles where the queue holds data but the pipeline owns
            // the port; any drain (or an empty queue) restarts the count.
            if (pop || queue_empty) begin
                starve_cnt <= '0;
            end else if (pipe_wb_en && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (pipe_wb_en && stall_req) begin
                perr_q <= 1'b1;
            end
        end
    end

    // Register 15 has no pending bit; such entries are still written.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (dest_q[i] != 4'hF)) begin
                pend_mask[dest_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        writeBackEn = 1'b0;
        Dest_wb     = '0;
        Result_wb   = '0;
        if (pipe_wb_en) begin
            writeBackEn = 1'b1;
            Dest_wb     = pipe_wb_dest;
            Result_wb   = pipe_wb_value;
        end else if (!queue_empty) begin
            writeBackEn = 1'b1;
            Dest_wb     = dest_q[rd_ptr];
            Result_wb   = value_q[rd_ptr];
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_wb_en;
    logic [3:0]  pipe_wb_dest;
    logic [31:0] pipe_wb_value;
    logic        aux_valid;
    logic        aux_ready;
    logic [3:0]  aux_dest;
    logic [31:0] aux_value;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_wb;
    logic [14:0] pend_mask;
    logic        stall_req;
    logic        protocol_err;

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_dest (pipe_wb_dest),
        .pipe_wb_value(pipe_wb_value),
        .aux_valid    (aux_valid),
        .aux_ready    (aux_ready),
        .aux_dest     (aux_dest),
        .aux_value    (aux_value),
        .writeBackEn  (writeBackEn),
        .Dest_wb      (Dest_wb),
        .Result_wb    (Result_wb),
        .pend_mask    (pend_mask),
        .stall_req    (stall_req),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic [3:0]  pd;
        logic [31:0] pv;
        logic        av;
        logic [3:0]  ad;
        logic [31:0] avv;
        logic        e_wbe;
        logic [3:0]  e_dest;
        logic [31:0] e_res;
        logic        e_rdy;
        logic [14:0] e_pend;
        logic        e_stall;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_perr = 1'b0;
    logic [35:0] sb_q[$];
    vec_t        vecs[16];

    function automatic vec_t mk(logic pe, logic [3:0] pd, logic [31:0] pv,
                                logic av, logic [3:0] ad, logic [31:0] avv,
                                logic e_wbe, logic [3:0] e_dest, logic [31:0] e_res,
                                logic e_rdy, logic [14:0] e_pend, logic e_stall);
        vec_t v;
        v.pe = pe; v.pd = pd; v.pv = pv;
        v.av = av; v.ad = ad; v.avv = avv;
        v.e_wbe = e_wbe; v.e_dest = e_dest; v.e_res = e_res;
        v.e_rdy = e_rdy; v.e_pend = e_pend; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every auxiliary write seen on the port must match the oldest accepted request.
    task automatic sb_pop(input string tag);
        logic [35:0] exp;
        if (writeBackEn && !pipe_wb_en) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s.sb_unexpected: got dest %0d value 0x%0h expected no aux write",
                         tag, Dest_wb, Result_wb);
            end else begin
                exp = sb_q.pop_front();
                check({tag, ".sb"}, {Dest_wb, Result_wb}, exp);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        pipe_wb_en    = v.pe;
        pipe_wb_dest  = v.pd;
        pipe_wb_value = v.pv;
        aux_valid     = v.av;
        aux_dest      = v.ad;
        aux_value     = v.avv;
        @(negedge clk);
        check({tag, ".wbe"},   36'(writeBackEn),  36'(v.e_wbe));
        check({tag, ".dest"},  36'(Dest_wb),      36'(v.e_dest));
        check({tag, ".res"},   36'(Result_wb),    36'(v.e_res));
        check({tag, ".rdy"},   36'(aux_ready),    36'(v.e_rdy));
        check({tag, ".pend"},  36'(pend_mask),    36'(v.e_pend));
        check({tag, ".stall"}, 36'(stall_req),    36'(v.e_stall));
        check({tag, ".perr"},  36'(protocol_err), 36'(exp_perr));
        sb_pop(tag);
        if (v.av && v.e_rdy) sb_q.push_back({v.ad, v.avv});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb_q.delete();
        exp_perr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 0, 0,            1, 3, 32'hDEAD0003, 0, 0, 0,            1, 15'h0000, 0);
        vecs[1]  = mk(0, 0, 0,            0, 0, 0,            1, 3, 32'hDEAD0003, 1, 15'h0008, 0);
        vecs[2]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 15'h0000, 0);
        vecs[3]  = mk(1, 1, 32'h11111111, 1, 5, 32'hA5,       1, 1, 32'h11111111, 1, 15'h0000, 0);
        vecs[4]  = mk(1, 2, 32'h22222222, 1, 7, 32'hA7,       1, 2, 32'h22222222, 1, 15'h0020, 0);
        vecs[5]  = mk(1, 1, 32'h33333333, 0, 0, 0,            1, 1, 32'h33333333, 0, 15'h00A0, 0);
        vecs[6]  = mk(1, 2, 32'h44444444, 1, 11, 32'hBB,      1, 2, 32'h44444444, 0, 15'h00A0, 0);
        vecs[7]  = mk(1, 1, 32'h55555555, 0, 0, 0,            1, 1, 32'h55555555, 0, 15'h00A0, 0);
        vecs[8]  = mk(0, 0, 0,            0, 0, 0,            1, 5, 32'hA5,       0, 15'h00A0, 1);
        vecs[9]  = mk(0, 0, 0,            0, 0, 0,            1, 7, 32'hA7,       1, 15'h0080, 0);
        vecs[10] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 15'h0000, 0);
        vecs[11] = mk(0, 0, 0,            1, 4, 32'h44,       0, 0, 0,            1, 15'h0000, 0);
        vecs[12] = mk(0, 0, 0,            1, 9, 32'h99,       1, 4, 32'h44,       1, 15'h0010, 0);
        vecs[13] = mk(0, 0, 0,            1, 15, 32'hFF,      1, 9, 32'h99,       1, 15'h0200, 0);
        vecs[14] = mk(0, 0, 0,            0, 0, 0,            1, 15, 32'hFF,      1, 15'h0000, 0);
        vecs[15] = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 15'h0000, 0);

        // Reset state: port follows the pipeline even while held in reset.
        rst           = 1'b0;
        pipe_wb_en    = 1'b1;
        pipe_wb_dest  = 4'd6;
        pipe_wb_value = 32'h66;
        aux_valid     = 1'b0;
        aux_dest      = '0;
        aux_value     = '0;
        #12;
        check("rst.wbe",   36'(writeBackEn),  36'd1);
        check("rst.dest",  36'(Dest_wb),      36'd6);
        check("rst.res",   36'(Result_wb),    36'h66);
        check("rst.rdy",   36'(aux_ready),    36'd1);
        check("rst.pend",  36'(pend_mask),    36'd0);
        check("rst.stall", 36'(stall_req),    36'd0);
        check("rst.perr",  36'(protocol_err), 36'd0);
        pipe_wb_en = 1'b0;
        do_reset();

        for (int i = 0; i < 16; i++) apply(vecs[i], $sformatf("vec%0d", i));
        check("vec.sb_drained", 36'(sb_q.size()), 36'd0);

        // Writing through an active stall is flagged and stays flagged.
        do_reset();
        apply(mk(1, 1, 32'h100, 1, 2, 32'h200, 1, 1, 32'h100, 1, 15'h0000, 0), "perr0");
        for (int i = 1; i <= 4; i++)
            apply(mk(1, 1, 32'h100 + i, 0, 0, 0, 1, 1, 32'h100 + i, 1, 15'h0004, 0),
                  $sformatf("perr%0d", i));
        apply(mk(1, 1, 32'h105, 0, 0, 0, 1, 1, 32'h105, 1, 15'h0004, 1), "perr5");
        exp_perr = 1'b1;
        apply(mk(0, 0, 0, 0, 0, 0, 1, 2, 32'h200, 1, 15'h0004, 1), "perr6");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,      1, 15'h0000, 0), "perr7");
        rst = 1'b0;
        #1;
        check("perr.rst", 36'(protocol_err), 36'd0);
        do_reset();

        // Reset with two queued entries drops them immediately.
        apply(mk(1, 1, 32'h1, 1, 8,  32'h800, 1, 1, 32'h1, 1, 15'h0000, 0), "mid0");
        apply(mk(1, 1, 32'h2, 1, 10, 32'hA00, 1, 1, 32'h2, 1, 15'h0100, 0), "mid1");
        pipe_wb_en = 1'b0;
        aux_valid  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mid.pend",  36'(pend_mask),   36'd0);
        check("mid.rdy",   36'(aux_ready),   36'd1);
        check("mid.stall", 36'(stall_req),   36'd0);
        check("mid.wbe",   36'(writeBackEn), 36'd0);
        do_reset();
        for (int i = 0; i < 3; i++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 15'h0000, 0), $sformatf("post%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
